// File: rtl/ofm_tile_collector_if.sv
// Tile hand-off bus between the OFM tile collector and the output memory writer.
// The master presents packed tiles with a valid/ready handshake; the slave accepts them.
interface ofm_tile_collector_if #(
  parameter int TILE_WIDTH = 64
) ();
  logic [TILE_WIDTH-1:0] tile_data;
  logic [15:0]           tile_index;
  logic                  tile_valid;
  logic                  tile_ready;

  modport master (
    output tile_data,
    output tile_index,
    output tile_valid,
    input  tile_ready
  );

  modport slave (
    input  tile_data,
    input  tile_index,
    input  tile_valid,
    output tile_ready
  );
endinterface

// File: rtl/ofm_tile_collector.sv
// Requantizes the serial OFM word stream, packs TILING_SIZE words per tile and buffers
// tiles in a 2-entry FIFO toward the output writer, tracking layer completion and data loss.
module ofm_tile_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 8,
  parameter int TILING_SIZE = 8,
  parameter int KERNEL_SIZE = 4096
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [3:0]            shift,
  input  logic [DATA_WIDTH-1:0] ofm,
  input  logic                  valid_data,
  ofm_tile_collector_if.master  tile_bus,
  output logic                  done,
  output logic                  overflow
);

  localparam int TILE_W    = TILING_SIZE * OUT_WIDTH;
  localparam int NUM_TILES = KERNEL_SIZE / TILING_SIZE;
  localparam int WC_W      = (TILING_SIZE > 1) ? $clog2(TILING_SIZE) : 1;

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(TILING_SIZE - 1);
  localparam logic [15:0]     LAST_TILE = 16'(NUM_TILES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Negative sums clamp to zero (ReLU); positive sums are shifted then saturated.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic [DATA_WIDTH-1:0] word,
                                                   input logic [3:0]            sh);
    logic [DATA_WIDTH-1:0] v;
    begin
      v = word >> sh;
      if (word[DATA_WIDTH-1]) begin
        requant = '0;
      end else if (v[DATA_WIDTH-1:OUT_WIDTH] != '0) begin
        requant = {OUT_WIDTH{1'b1}};
      end else begin
        requant = v[OUT_WIDTH-1:0];
      end
    end
  endfunction

  logic [1:0]        state_r, state_nxt_s;
  logic [WC_W-1:0]   word_cnt_r;
  logic [15:0]       tile_cnt_r;
  logic [TILE_W-1:0] pack_r, new_tile_s;
  logic [TILE_W-1:0] d0_r, d1_r, d0_nxt_s, d1_nxt_s;
  logic [15:0]       i0_r, i1_r, i0_nxt_s, i1_nxt_s;
  logic              v0_r, v1_r, v0_nxt_s, v1_nxt_s;
  logic              drop_s, word_acc_s, tile_done_s, pop_s, late_word_s;
  logic              done_r, overflow_r;
  logic [OUT_WIDTH-1:0] elem_s;

  // Word acceptance and tile completion decode.
  always_comb begin
    word_acc_s  = valid_data && ((state_r == ST_IDLE) || (state_r == ST_COLLECT));
    late_word_s = valid_data && ((state_r == ST_FLUSH) || (state_r == ST_DONE));
    tile_done_s = word_acc_s && (word_cnt_r == LAST_WORD);
    pop_s       = v0_r && tile_bus.tile_ready;
    elem_s      = requant(ofm, shift);
  end

  // Insert the current element into its slot of the tile under construction.
  always_comb begin
    new_tile_s = pack_r;
    for (int k = 0; k < TILING_SIZE; k++) begin
      if (word_cnt_r == WC_W'(k)) begin
        new_tile_s[k*OUT_WIDTH +: OUT_WIDTH] = elem_s;
      end else begin
        new_tile_s[k*OUT_WIDTH +: OUT_WIDTH] = pack_r[k*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Shift-register FIFO: slot 0 is always the head so the outputs come straight from flops.
  always_comb begin
    d0_nxt_s = d0_r;
    d1_nxt_s = d1_r;
    i0_nxt_s = i0_r;
    i1_nxt_s = i1_r;
    v0_nxt_s = v0_r;
    v1_nxt_s = v1_r;
    drop_s   = 1'b0;
    case ({tile_done_s, pop_s})
      2'b11: begin
        if (v1_r) begin
          d0_nxt_s = d1_r;
          i0_nxt_s = i1_r;
          d1_nxt_s = new_tile_s;
          i1_nxt_s = tile_cnt_r;
        end else begin
          d0_nxt_s = new_tile_s;
          i0_nxt_s = tile_cnt_r;
        end
      end
      2'b01: begin
        d0_nxt_s = d1_r;
        i0_nxt_s = i1_r;
        v0_nxt_s = v1_r;
        v1_nxt_s = 1'b0;
      end
      2'b10: begin
        if (!v0_r) begin
          d0_nxt_s = new_tile_s;
          i0_nxt_s = tile_cnt_r;
          v0_nxt_s = 1'b1;
        end else if (!v1_r) begin
          d1_nxt_s = new_tile_s;
          i1_nxt_s = tile_cnt_r;
          v1_nxt_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end
      default: begin
        drop_s = 1'b0;
      end
    endcase
  end

  // Layer sequencing: collect, then drain the FIFO before reporting done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (word_acc_s) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (tile_done_s && (tile_cnt_r == LAST_TILE)) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_FLUSH: begin
        if (!v0_nxt_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, packing register and FIFO storage; clr acts exactly like reset.
  always_ff @(posedge clk1) begin
    if (!rst_n || clr) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= '0;
      tile_cnt_r <= 16'd0;
      pack_r     <= '0;
      d0_r       <= '0;
      d1_r       <= '0;
      i0_r       <= 16'd0;
      i1_r       <= 16'd0;
      v0_r       <= 1'b0;
      v1_r       <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (word_acc_s) begin
        pack_r     <= new_tile_s;
        word_cnt_r <= tile_done_s ? '0 : word_cnt_r + WC_W'(1);
      end else begin
        pack_r     <= pack_r;
        word_cnt_r <= word_cnt_r;
      end
      // Dropped tiles still advance the count so indices track kernel position.
      if (tile_done_s) begin
        tile_cnt_r <= tile_cnt_r + 16'd1;
      end else begin
        tile_cnt_r <= tile_cnt_r;
      end
      d0_r       <= d0_nxt_s;
      d1_r       <= d1_nxt_s;
      i0_r       <= i0_nxt_s;
      i1_r       <= i1_nxt_s;
      v0_r       <= v0_nxt_s;
      v1_r       <= v1_nxt_s;
      done_r     <= (state_nxt_s == ST_DONE);
      overflow_r <= overflow_r || drop_s || late_word_s;
    end
  end

  assign tile_bus.tile_data  = d0_r;
  assign tile_bus.tile_index = i0_r;
  assign tile_bus.tile_valid = v0_r;
  assign done                = done_r;
  assign overflow            = overflow_r;

endmodule

// File: tb/tb_ofm_tile_collector.sv
// Scoreboard bench for ofm_tile_collector: expected tiles are queued as words are driven
// and compared against the FIFO head whenever a tile is presented.
module tb_ofm_tile_collector;

  localparam int TW = 64;

  logic        clk1 = 1'b0;
  logic        rst_n, clr, valid_data;
  logic [3:0]  shift;
  logic [15:0] ofm;
  logic        done, overflow;

  always #5 clk1 = ~clk1;

  ofm_tile_collector_if #(.TILE_WIDTH(TW)) tile_if ();

  ofm_tile_collector #(
    .DATA_WIDTH (16),
    .OUT_WIDTH  (8),
    .TILING_SIZE(8),
    .KERNEL_SIZE(32)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .clr       (clr),
    .shift     (shift),
    .ofm       (ofm),
    .valid_data(valid_data),
    .tile_bus  (tile_if),
    .done      (done),
    .overflow  (overflow)
  );

  typedef struct {
    logic [63:0] data;
    logic [15:0] idx;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          toggle_ready = 1'b0;
  logic [15:0] wbuf[8];
  logic [3:0]  sbuf[8];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [7:0] model_rq(input logic [15:0] w, input logic [3:0] s);
    logic [31:0] v;
    if (w[15]) return 8'h00;
    v = {16'h0000, w} >> s;
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [63:0] model_tile();
    logic [63:0] t;
    t = 64'h0;
    for (int i = 0; i < 8; i++) t[i*8 +: 8] = model_rq(wbuf[i], sbuf[i]);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic [3:0] s);
    ofm        = w;
    shift      = s;
    valid_data = 1'b1;
    if (toggle_ready) tile_if.tile_ready = ~tile_if.tile_ready;
    tick();
    valid_data = 1'b0;
  endtask

  task automatic send_tile(input bit keep, input logic [63:0] exp_data, input logic [15:0] idx);
    exp_t e;
    e.data = exp_data;
    e.idx  = idx;
    if (keep) exp_q.push_back(e);
    for (int i = 0; i < 8; i++) send_word(wbuf[i], sbuf[i]);
  endtask

  // Scoreboard: the presented head must match the oldest expected tile every cycle it is valid.
  always @(negedge clk1) begin
    if (rst_n && !clr && tile_if.tile_valid) begin
      check_val("tile_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check_val("tile_data", tile_if.tile_data, exp_q[0].data);
        check_val("tile_index", 64'(tile_if.tile_index), 64'(exp_q[0].idx));
        if (tile_if.tile_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, 64'(tile_if.tile_valid), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_ovf"}, 64'(overflow), 64'd0);
    check_val({tag, "_index"}, 64'(tile_if.tile_index), 64'd0);
    check_val({tag, "_data"}, tile_if.tile_data, 64'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; clr = 1'b0; valid_data = 1'b0; ofm = 16'h0; shift = 4'd0;
    tile_if.tile_ready = 1'b0;
    tick(); tick();
    check_idle_outputs("rst");
    rst_n = 1'b1;
    tick(); tick(); tick();
    check_idle_outputs("post_rst");

    // Basic packing, one-cycle latency and single-cycle valid pulse.
    tile_if.tile_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin wbuf[i] = 16'(i + 1); sbuf[i] = 4'd0; end
    send_tile(1'b1, 64'h0807060504030201, 16'd0);
    check_val("first_valid_latency", 64'(tile_if.tile_valid), 64'd1);
    tick();
    check_val("first_valid_pulse", 64'(tile_if.tile_valid), 64'd0);

    // Requantization corner cases with per-word shift.
    wbuf = '{16'hFF00, 16'h1234, 16'h0050, 16'h00FF, 16'h0100, 16'h0010, 16'h7FFF, 16'h7FFF};
    sbuf = '{4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd2, 4'd15, 4'd8};
    send_tile(1'b1, 64'h7F0004FFFF05FF00, 16'd1);
    tick(); tick();
    do_clr();

    // Backpressure: two tiles held, third dropped, index keeps counting.
    tile_if.tile_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) begin wbuf[i] = 16'(t * 16 + i * 3 + 1); sbuf[i] = 4'd0; end
      send_tile(t < 2, model_tile(), 16'(t));
    end
    check_val("bp_overflow", 64'(overflow), 64'd1);
    check_val("bp_held_valid", 64'(tile_if.tile_valid), 64'd1);
    tick(); tick(); tick(); tick();
    tile_if.tile_ready = 1'b1;
    tick(); tick(); tick();
    check_val("bp_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) begin wbuf[i] = 16'(16'h0200 + i * 40); sbuf[i] = 4'd2; end
    send_tile(1'b1, model_tile(), 16'd3);
    check_val("bp_done_before", 64'(done), 64'd0);
    tick();
    check_val("bp_done_after", 64'(done), 64'd1);
    check_val("bp_valid_after", 64'(tile_if.tile_valid), 64'd0);
    do_clr();
    check_val("clr_done", 64'(done), 64'd0);
    check_val("clr_ovf", 64'(overflow), 64'd0);

    // Full layer with toggling ready and random words; done one cycle after last handshake.
    tile_if.tile_ready = 1'b0;
    toggle_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) begin
        wbuf[i] = 16'($urandom());
        sbuf[i] = 4'($urandom_range(0, 15));
      end
      send_tile(1'b1, model_tile(), 16'(t));
    end
    toggle_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tile_if.tile_ready = ~tile_if.tile_ready;
      if (tile_if.tile_valid && tile_if.tile_ready && exp_q.size() == 1) begin
        check_val("layer_done_before", 64'(done), 64'd0);
        tick();
        check_val("layer_done_after", 64'(done), 64'd1);
        found = 1'b1;
      end else begin
        tick();
      end
    end
    check_val("layer_done_seen", 64'(found), 64'd1);
    check_val("layer_no_ovf", 64'(overflow), 64'd0);
    send_word(16'h0001, 4'd0);
    tick();
    check_val("late_word_ovf", 64'(overflow), 64'd1);
    check_val("late_word_no_tile", 64'(tile_if.tile_valid), 64'd0);
    check_val("late_word_done", 64'(done), 64'd1);
    do_clr();

    // clr mid-tile discards partial words; clr with valid_data discards that word.
    tile_if.tile_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_word(16'(16'h00AA + i), 4'd0);
    do_clr();
    for (int i = 0; i < 8; i++) begin wbuf[i] = 16'(16'h0010 + i); sbuf[i] = 4'd0; end
    send_tile(1'b1, model_tile(), 16'd0);
    tick(); tick();
    do_clr();
    clr = 1'b1; valid_data = 1'b1; ofm = 16'h0099; shift = 4'd0;
    tick();
    clr = 1'b0; valid_data = 1'b0;
    for (int i = 0; i < 8; i++) begin wbuf[i] = 16'(16'h0020 + i); sbuf[i] = 4'd0; end
    send_tile(1'b1, model_tile(), 16'd0);
    tick(); tick();
    check_val("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check_val("final_ovf", 64'(overflow), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
